// File: rtl/carrier_code_correlator.sv
// Carrier/code wipe-off correlator: XORs the sign sample with the 1-bit carrier and the
// C/A chip, integrates the +/-1 products over INT_LEN accepted samples, then dumps sum and magnitude.
module carrier_code_correlator #(
  parameter int INT_LEN = 16000,
  parameter int ACC_W   = 16,
  parameter int CNT_W   = 14,
  parameter int DUMP_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic                     sample,
  input  logic                     carrier,
  input  logic                     code,
  input  logic                     sync_clr,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic        [ACC_W-1:0]  acc_mag,
  output logic                     acc_valid,
  output logic        [DUMP_W-1:0] dump_cnt,
  output logic                     busy
);

  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_INTEGRATE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INT_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] PLUS_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

  if (INT_LEN < 2) begin : g_chk_len
    $error("carrier_code_correlator: INT_LEN must be at least 2");
  end
  if (((64'd1 << (ACC_W - 1)) - 64'd1) < 64'(INT_LEN)) begin : g_chk_acc_w
    $error("carrier_code_correlator: ACC_W too narrow for INT_LEN");
  end
  if ((64'd1 << CNT_W) < 64'(INT_LEN)) begin : g_chk_cnt_w
    $error("carrier_code_correlator: CNT_W too narrow for INT_LEN");
  end

  state_t                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic        [ACC_W-1:0]   acc_mag_q, acc_mag_d;
  logic                      valid_q, valid_d;
  logic        [DUMP_W-1:0]  dump_q, dump_d;
  logic                      busy_q, busy_d;

  logic                      product;
  logic signed [ACC_W-1:0]   contrib;
  logic signed [ACC_W-1:0]   sum;
  logic        [ACC_W-1:0]   sum_mag;

  // Wipe-off product and the running sum including this sample.
  always_comb begin
    product = sample ^ carrier ^ code;
    contrib = product ? {ACC_W{1'b1}} : PLUS_ONE;
    sum     = acc_q + contrib;
    sum_mag = sum[ACC_W-1] ? (~sum + PLUS_ONE) : sum;
  end

  // Next-state logic: abort beats accept; the final accepted sample dumps and rewinds.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    acc_mag_d = acc_mag_q;
    valid_d   = 1'b0;
    dump_d    = dump_q;
    busy_d    = busy_q;

    if (sync_clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (sample_en) begin
      case (state_q)
        S_IDLE: begin
          // INT_LEN >= 2, so the opening sample can never be the final one.
          state_d = S_INTEGRATE;
          cnt_d   = ONE_CNT;
          acc_d   = contrib;
        end
        S_INTEGRATE: begin
          if (cnt_q == LAST_CNT) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            acc_out_d = sum;
            acc_mag_d = sum_mag;
            valid_d   = 1'b1;
            dump_d    = dump_q + {{(DUMP_W-1){1'b0}}, 1'b1};
          end else begin
            state_d = S_INTEGRATE;
            cnt_d   = cnt_q + ONE_CNT;
            acc_d   = sum;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    case (state_d)
      S_IDLE:      busy_d = 1'b0;
      S_INTEGRATE: busy_d = 1'b1;
      default:     busy_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      acc_mag_q <= '0;
      valid_q   <= 1'b0;
      dump_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      acc_mag_q <= acc_mag_d;
      valid_q   <= valid_d;
      dump_q    <= dump_d;
      busy_q    <= busy_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_mag   = acc_mag_q;
  assign acc_valid = valid_q;
  assign dump_cnt  = dump_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_carrier_code_correlator.sv
// Directed bench for carrier_code_correlator: four instances (INT_LEN 16000/8/4/2) share the
// inputs, one active at a time; a model pushes expected dumps that a negedge monitor pops.
module tb_carrier_code_correlator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sen;
  logic        smp, car, cod, clr;
  logic [15:0] ao [4];
  logic [15:0] am [4];
  logic [3:0]  av;
  logic [7:0]  dc [4];
  logic [3:0]  bz;

  typedef struct {
    int          idx;
    logic [15:0] acc;
    logic [15:0] mag;
    logic [7:0]  dc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   lens [4] = '{16000, 8, 4, 2};
  int   macc [4];
  int   mcnt [4];
  int   mdump[4];

  always #5 clk = ~clk;

  carrier_code_correlator u_dut0 (
    .clk(clk), .rst(rst), .sample_en(sen[0]), .sample(smp), .carrier(car), .code(cod),
    .sync_clr(clr), .acc_out(ao[0]), .acc_mag(am[0]), .acc_valid(av[0]),
    .dump_cnt(dc[0]), .busy(bz[0]));

  carrier_code_correlator #(.INT_LEN(8)) u_dut1 (
    .clk(clk), .rst(rst), .sample_en(sen[1]), .sample(smp), .carrier(car), .code(cod),
    .sync_clr(clr), .acc_out(ao[1]), .acc_mag(am[1]), .acc_valid(av[1]),
    .dump_cnt(dc[1]), .busy(bz[1]));

  carrier_code_correlator #(.INT_LEN(4)) u_dut2 (
    .clk(clk), .rst(rst), .sample_en(sen[2]), .sample(smp), .carrier(car), .code(cod),
    .sync_clr(clr), .acc_out(ao[2]), .acc_mag(am[2]), .acc_valid(av[2]),
    .dump_cnt(dc[2]), .busy(bz[2]));

  carrier_code_correlator #(.INT_LEN(2)) u_dut3 (
    .clk(clk), .rst(rst), .sample_en(sen[3]), .sample(smp), .carrier(car), .code(cod),
    .sync_clr(clr), .acc_out(ao[3]), .acc_mag(am[3]), .acc_valid(av[3]),
    .dump_cnt(dc[3]), .busy(bz[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      macc[j]  = 0;
      mcnt[j]  = 0;
      mdump[j] = 0;
    end
  endtask

  // Drive one cycle of stimulus to instance i, update the model, return 1 time unit after the edge.
  task automatic step(input int i, input logic en, input logic s, input logic c,
                      input logic k, input logic cl);
    exp_t e;
    sen    = 4'b0000;
    sen[i] = en;
    smp    = s;
    car    = c;
    cod    = k;
    clr    = cl;
    if (cl) begin
      for (int j = 0; j < 4; j++) begin
        macc[j] = 0;
        mcnt[j] = 0;
      end
    end else if (en) begin
      macc[i] += (s ^ c ^ k) ? -1 : 1;
      mcnt[i]++;
      if (mcnt[i] == lens[i]) begin
        mdump[i] = (mdump[i] + 1) % 256;
        e.idx = i;
        e.acc = 16'(macc[i]);
        e.mag = 16'((macc[i] < 0) ? -macc[i] : macc[i]);
        e.dc  = 8'(mdump[i]);
        sb.push_back(e);
        macc[i] = 0;
        mcnt[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (av[i] === 1'b1) begin
          tests++;
          assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_valid dut=%0d observed=1 expected=0", i);
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("dump_dut_idx", 32'(i), 32'(e.idx));
            chk("acc_out", {16'h0, ao[i]}, {16'h0, e.acc});
            chk("acc_mag", {16'h0, am[i]}, {16'h0, e.mag});
            chk("dump_cnt", {24'h0, dc[i]}, {24'h0, e.dc});
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sen = 4'b0000;
    smp = 1'b0; car = 1'b0; cod = 1'b0; clr = 1'b0;
    model_reset();
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset_acc_out", {16'h0, ao[i]}, 32'h0);
      chk("reset_acc_mag", {16'h0, am[i]}, 32'h0);
      chk("reset_valid", {31'h0, av[i]}, 32'h0);
      chk("reset_dump_cnt", {24'h0, dc[i]}, 32'h0);
      chk("reset_busy", {31'h0, bz[i]}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Default length: +16000, then -16000, then +16000 with code wiping the inverted sample.
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_after_first", {31'h0, bz[0]}, 32'h1);
    for (int n = 1; n < 16000; n++) step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("latency_w1", {31'h0, av[0]}, 32'h1);
    chk("busy_after_dump", {31'h0, bz[0]}, 32'h0);
    for (int n = 0; n < 16000; n++) step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("neg_acc_out", {16'h0, ao[0]}, 32'h0000C180);
    for (int n = 0; n < 16000; n++) step(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("valid_one_cycle", {31'h0, av[0]}, 32'h0);
    chk("dump_cnt_3", {24'h0, dc[0]}, 32'h3);

    // INT_LEN=8 with a strobe every third cycle; outputs hold across gaps.
    for (int k = 1; k <= 8; k++) begin
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k < 8) begin
        step(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("gap_no_valid", {31'h0, av[1]}, 32'h0);
        chk("gap_busy", {31'h0, bz[1]}, 32'h1);
        step(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    chk("gap_latency", {31'h0, av[1]}, 32'h1);
    step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_acc_out", {16'h0, ao[1]}, 32'h8);
    chk("hold_valid_low", {31'h0, av[1]}, 32'h0);

    // sync_clr after 5 samples, with a simultaneous strobe.
    for (int n = 0; n < 5; n++) step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_busy", {31'h0, bz[1]}, 32'h0);
    chk("clr_no_valid", {31'h0, av[1]}, 32'h0);
    chk("clr_dump_cnt", {24'h0, dc[1]}, 32'h1);
    chk("clr_acc_out_kept", {16'h0, ao[1]}, 32'h8);
    for (int n = 0; n < 7; n++) step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_clr_7_no_valid", {31'h0, av[1]}, 32'h0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_clr_8_valid", {31'h0, av[1]}, 32'h1);

    // sync_clr on the would-be final sample.
    for (int n = 0; n < 7; n++) step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_final_no_valid", {31'h0, av[1]}, 32'h0);
    chk("clr_final_dump_cnt", {24'h0, dc[1]}, 32'h2);
    chk("clr_final_busy", {31'h0, bz[1]}, 32'h0);

    // Carrier toggling with sample=code=0 nets to zero.
    for (int n = 0; n < 8; n++) step(1, 1'b1, 1'b0, 1'(n % 2), 1'b0, 1'b0);
    chk("toggle_acc_mag", {16'h0, am[1]}, 32'h0);

    // INT_LEN=4, products 0,0,0,1 -> +2.
    step(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("len4_acc_out", {16'h0, ao[2]}, 32'h2);

    // INT_LEN=2: dump counter wraps 255 -> 0.
    for (int n = 0; n < 255 * 2; n++) step(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dump_cnt_255", {24'h0, dc[3]}, 32'hFF);
    step(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dump_cnt_wrap", {24'h0, dc[3]}, 32'h0);
    step(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_busy", {31'h0, bz[3]}, 32'h1);

    // Asynchronous reset mid-window, away from any clock edge.
    #1;
    rst = 1'b1;
    #1;
    chk("arst_acc_out", {16'h0, ao[3]}, 32'h0);
    chk("arst_acc_mag", {16'h0, am[3]}, 32'h0);
    chk("arst_dump_cnt", {24'h0, dc[3]}, 32'h0);
    chk("arst_busy", {31'h0, bz[3]}, 32'h0);
    chk("arst_dump_cnt0", {24'h0, dc[0]}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_first_no_valid", {31'h0, av[3]}, 32'h0);
    step(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_second_valid", {31'h0, av[3]}, 32'h1);
    step(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
